paddle_ctrl: RTL

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/pong_pkg.sv | 16 +
 rtl/paddle_ctrl_if.sv | 26 ++
 rtl/btn_debounce.sv | 39 +++
 rtl/paddle_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the paddle controller: per-player FSM states and
// the recentre position helper.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    BLOCKED   = 2'd3
  } paddle_state_e;

  function automatic int center_of(input int lo, input int hi);
    return (lo + hi) / 2;
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Control and status bundle of the paddle controller; master is the game
// side driving buttons and timing, slave is the controller.
interface paddle_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int POS_W       = 10
);
  logic                         frame_tick;
  logic                         mode;
  logic                         center;
  logic [NUM_PLAYERS-1:0]       btn_up;
  logic [NUM_PLAYERS-1:0]       btn_down;
  logic [NUM_PLAYERS*POS_W-1:0] pos;
  logic [NUM_PLAYERS-1:0]       at_min;
  logic [NUM_PLAYERS-1:0]       at_max;
  logic [NUM_PLAYERS-1:0]       moving;

  modport master (
    output frame_tick, mode, center, btn_up, btn_down,
    input  pos, at_min, at_max, moving
  );

  modport slave (
    input  frame_tick, mode, center, btn_up, btn_down,
    output pos, at_min, at_max, moving
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter; the accepted level
// follows the synchronised input only after DEBOUNCE_CYC unbroken cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;

  // synchronise the raw input and count consecutive disagreeing cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_r  <= 2'b00;
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], raw};
      if (sync_r[1] == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        cnt_r   <= '0;
        level_r <= sync_r[1];
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign level = level_r;

endmodule

// File: rtl/paddle_ctrl.sv
// Multi-player paddle controller: debounced buttons drive a per-player FSM
// that moves a clamped position continuously or one step per press.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int POS_W        = 10,
  parameter int POS_MIN      = 0,
  parameter int POS_MAX      = 400,
  parameter int STEP         = 4,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic          clock,
  input  logic          reset,
  paddle_ctrl_if.slave  bus
);
  localparam int POS_WX = POS_W + 1;
  localparam logic [POS_W-1:0]  CENTER_POS = POS_W'(center_of(POS_MIN, POS_MAX));
  localparam logic [POS_W-1:0]  MIN_V      = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0]  MAX_V      = POS_W'(POS_MAX);
  localparam logic [POS_W:0]    MIN_EXT    = POS_WX'(POS_MIN);
  localparam logic [POS_W:0]    MAX_EXT    = POS_WX'(POS_MAX);
  localparam logic [POS_W:0]    STEP_EXT   = POS_WX'(STEP);

  // one extra bit keeps both directions free of wrap-around before clamping
  function automatic logic [POS_W-1:0] step_toward_min(input logic [POS_W-1:0] p);
    logic [POS_W:0] ext_s;
    ext_s = {1'b0, p};
    if (ext_s < MIN_EXT + STEP_EXT) return MIN_V;
    else                           return POS_W'(ext_s - STEP_EXT);
  endfunction

  function automatic logic [POS_W-1:0] step_toward_max(input logic [POS_W-1:0] p);
    logic [POS_W:0] sum_s;
    sum_s = {1'b0, p} + STEP_EXT;
    if (sum_s > MAX_EXT) return MAX_V;
    else                 return POS_W'(sum_s);
  endfunction

  logic mode_r;
  logic mode_chg_s;

  logic [POS_W-1:0] pos_arr_s    [NUM_PLAYERS];
  logic             at_min_arr_s [NUM_PLAYERS];
  logic             at_max_arr_s [NUM_PLAYERS];
  logic             moving_arr_s [NUM_PLAYERS];

  // mode is applied one cycle late so a change can flush pending presses first
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mode_r <= 1'b0;
    else       mode_r <= bus.mode;
  end

  assign mode_chg_s = (bus.mode != mode_r);

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    logic             up_acc_s, dn_acc_s;
    logic             up_prev_r, dn_prev_r;
    logic             pend_up_r, pend_dn_r, pend_up_next_s, pend_dn_next_s;
    logic             go_up_s, go_dn_s;
    paddle_state_e    state_r, state_next_s;
    logic [POS_W-1:0] pos_r, pos_next_s;
    logic             at_min_r, at_max_r, moving_r;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
      .clock(clock), .reset(reset), .raw(bus.btn_up[gi]), .level(up_acc_s)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
      .clock(clock), .reset(reset), .raw(bus.btn_down[gi]), .level(dn_acc_s)
    );

    // state follows the accepted button combination
    always_comb begin
      case ({up_acc_s, dn_acc_s})
        2'b10:   state_next_s = MOVE_UP;
        2'b01:   state_next_s = MOVE_DOWN;
        2'b11:   state_next_s = BLOCKED;
        default: state_next_s = IDLE;
      endcase
    end

    // movement request and per-direction pending presses for step mode
    always_comb begin
      go_up_s        = 1'b0;
      go_dn_s        = 1'b0;
      pend_up_next_s = pend_up_r;
      pend_dn_next_s = pend_dn_r;
      if (mode_r) begin
        if (bus.frame_tick) begin
          go_up_s        = pend_up_r & ~pend_dn_r;
          go_dn_s        = pend_dn_r & ~pend_up_r;
          pend_up_next_s = up_acc_s & ~up_prev_r;
          pend_dn_next_s = dn_acc_s & ~dn_prev_r;
        end else begin
          pend_up_next_s = pend_up_r | (up_acc_s & ~up_prev_r);
          pend_dn_next_s = pend_dn_r | (dn_acc_s & ~dn_prev_r);
        end
      end else begin
        go_up_s = bus.frame_tick & (state_r == MOVE_UP);
        go_dn_s = bus.frame_tick & (state_r == MOVE_DOWN);
      end
      if (bus.center || mode_chg_s) begin
        pend_up_next_s = 1'b0;
        pend_dn_next_s = 1'b0;
      end else begin
        pend_up_next_s = pend_up_next_s;
        pend_dn_next_s = pend_dn_next_s;
      end
    end

    // recentre wins over any movement in the same cycle
    always_comb begin
      if (bus.center)   pos_next_s = CENTER_POS;
      else if (go_up_s) pos_next_s = step_toward_min(pos_r);
      else if (go_dn_s) pos_next_s = step_toward_max(pos_r);
      else              pos_next_s = pos_r;
    end

    // player FSM with registered position and status flags
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_r   <= IDLE;
        pos_r     <= CENTER_POS;
        at_min_r  <= (CENTER_POS == MIN_V);
        at_max_r  <= (CENTER_POS == MAX_V);
        moving_r  <= 1'b0;
        up_prev_r <= 1'b0;
        dn_prev_r <= 1'b0;
        pend_up_r <= 1'b0;
        pend_dn_r <= 1'b0;
      end else begin
        state_r   <= state_next_s;
        pos_r     <= pos_next_s;
        at_min_r  <= (pos_next_s == MIN_V);
        at_max_r  <= (pos_next_s == MAX_V);
        moving_r  <= (state_next_s == MOVE_UP) || (state_next_s == MOVE_DOWN);
        up_prev_r <= up_acc_s;
        dn_prev_r <= dn_acc_s;
        pend_up_r <= pend_up_next_s;
        pend_dn_r <= pend_dn_next_s;
      end
    end

    assign pos_arr_s[gi]    = pos_r;
    assign at_min_arr_s[gi] = at_min_r;
    assign at_max_arr_s[gi] = at_max_r;
    assign moving_arr_s[gi] = moving_r;
  end

  // pack per-player registers onto the bus
  always_comb begin
    bus.pos    = '0;
    bus.at_min = '0;
    bus.at_max = '0;
    bus.moving = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      bus.pos[i*POS_W +: POS_W] = pos_arr_s[i];
      bus.at_min[i]             = at_min_arr_s[i];
      bus.at_max[i]             = at_max_arr_s[i];
      bus.moving[i]             = moving_arr_s[i];
    end
  end

endmodule
